// File: rtl/full_subtractor_s_pkg.sv
// Shared constants for the full_subtractor_s leaf cell: default counter width
// and the reference truth table {d,bout} indexed by {a,b,borrow_in}.
package full_subtractor_s_pkg;

   localparam int CNT_W_DEFAULT = 16;

   // Entry i occupies bits [2i+1:2i]; entry 7 (a=b=bin=1) is the leftmost pair.
   localparam logic [15:0] FS_TRUTH = 16'b11_00_00_10_01_11_11_00;

endpackage

// File: rtl/full_subtractor_s_half_subtractor.sv
// Half subtractor: d = a ^ b, borrow = ~a & b. Building block of the full
// subtractor core.
module half_subtractor (
   input  logic a,
   input  logic b,
   output logic d,
   output logic borrow
);

   assign d      = a ^ b;
   assign borrow = ~a & b;

endmodule

// File: rtl/full_subtractor_s.sv
// 1-bit full subtractor (a - b - borrow_in): structural combinational core plus
// a valid-qualified output register. Define FULL_SUBTRACTOR_S_STATS_EN to add
// saturating op/borrow counters.
module full_subtractor_s
   import full_subtractor_s_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             a,
   input  logic             b,
   input  logic             borrow_in,
   input  logic             in_valid,
   output logic             d,
   output logic             borrow_out,
   output logic             d_q,
   output logic             borrow_out_q,
`ifdef FULL_SUBTRACTOR_S_STATS_EN
   output logic [CNT_W-1:0] op_count,
   output logic [CNT_W-1:0] borrow_count,
`endif
   output logic             out_valid
);

   logic d1_p0;
   logic b1_p0;
   logic d_p0;
   logic b2_p0;
   logic bout_p0;

   // ---- stage p0: combinational core ----
   half_subtractor u_hs1 (
      .a      (a),
      .b      (b),
      .d      (d1_p0),
      .borrow (b1_p0)
   );

   half_subtractor u_hs2 (
      .a      (d1_p0),
      .b      (borrow_in),
      .d      (d_p0),
      .borrow (b2_p0)
   );

   assign bout_p0    = b1_p0 | b2_p0;
   assign d          = d_p0;
   assign borrow_out = bout_p0;

   // ---- stage p1: output register ----
   logic d_p1;
   logic bout_p1;
   logic vld_p1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1  <= 1'b0;
         d_p1    <= 1'b0;
         bout_p1 <= 1'b0;
      end else begin
         vld_p1 <= in_valid;
         if (in_valid) begin
            d_p1    <= d_p0;
            bout_p1 <= bout_p0;
         end
      end
   end

   assign d_q          = d_p1;
   assign borrow_out_q = bout_p1;
   assign out_valid    = vld_p1;

`ifdef FULL_SUBTRACTOR_S_STATS_EN
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   logic [CNT_W-1:0] op_cnt_p1;
   logic [CNT_W-1:0] bor_cnt_p1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_cnt_p1  <= '0;
         bor_cnt_p1 <= '0;
      end else if (in_valid) begin
         op_cnt_p1 <= sat_inc(op_cnt_p1);
         if (bout_p0)
            bor_cnt_p1 <= sat_inc(bor_cnt_p1);
      end
   end

   assign op_count     = op_cnt_p1;
   assign borrow_count = bor_cnt_p1;
`endif

   // Cross-check the structural core against the packaged truth table.
   logic [3:0] tt_idx;
   assign tt_idx = {a, b, borrow_in, 1'b0};

   if (CNT_W >= 1) begin : g_core_chk
      a_core_truth : assert property (@(posedge clk) disable iff (!rst_n)
         {d_p0, bout_p0} == FS_TRUTH[tt_idx +: 2]);
   end

endmodule

// File: tb/tb_full_subtractor_s.sv
// Directed bench for full_subtractor_s: arithmetic reference model checked on
// every clock plus hand-computed literal expectations.
module tb_full_subtractor_s;

`ifdef FULL_SUBTRACTOR_S_STATS_EN
   localparam int TB_CNT_W = 2;
`else
   localparam int TB_CNT_W = 16;
`endif

   logic clk = 1'b0;
   logic clk_en = 1'b0;
   logic rst_n;
   logic a, b, borrow_in, in_valid;
   logic d, borrow_out, d_q, borrow_out_q, out_valid;
`ifdef FULL_SUBTRACTOR_S_STATS_EN
   logic [TB_CNT_W-1:0] op_count, borrow_count;
`endif

   int n_vec = 0;
   int n_err = 0;
   logic cmp_en = 1'b0;

   // Hand-written truth table, index {a,b,bin}, value {d,bout}.
   logic [1:0] tt_lit [8] = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};

   full_subtractor_s #(.CNT_W(TB_CNT_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .a            (a),
      .b            (b),
      .borrow_in    (borrow_in),
      .in_valid     (in_valid),
      .d            (d),
      .borrow_out   (borrow_out),
      .d_q          (d_q),
      .borrow_out_q (borrow_out_q),
`ifdef FULL_SUBTRACTOR_S_STATS_EN
      .op_count     (op_count),
      .borrow_count (borrow_count),
`endif
      .out_valid    (out_valid)
   );

   always begin
      #5;
      if (clk_en) clk = ~clk;
   end

   // Reference: signed arithmetic a - b - bin; d is the low bit, borrow is sign.
   function automatic logic [1:0] model(input logic ma, input logic mb, input logic mc);
      int r;
      r = int'(ma) - int'(mb) - int'(mc);
      return {r[0], (r < 0)};
   endfunction

   task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   logic m_vld, m_d, m_b;
   logic [1:0] m_r;
`ifdef FULL_SUBTRACTOR_S_STATS_EN
   int m_op, m_bc;
   localparam int CMAX = (1 << TB_CNT_W) - 1;
`endif

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_vld = 1'b0; m_d = 1'b0; m_b = 1'b0;
`ifdef FULL_SUBTRACTOR_S_STATS_EN
         m_op = 0; m_bc = 0;
`endif
      end else begin
         m_vld = in_valid;
         if (in_valid) begin
            m_r = model(a, b, borrow_in);
            m_d = m_r[1];
            m_b = m_r[0];
`ifdef FULL_SUBTRACTOR_S_STATS_EN
            if (m_op < CMAX) m_op++;
            if (m_r[0] && m_bc < CMAX) m_bc++;
`endif
         end
      end
      if (cmp_en && clk) begin
         #1;
         check1("cyc_out_valid", {31'b0, out_valid}, {31'b0, m_vld});
         check1("cyc_d_q", {31'b0, d_q}, {31'b0, m_d});
         check1("cyc_borrow_q", {31'b0, borrow_out_q}, {31'b0, m_b});
         check1("cyc_comb", {30'b0, d, borrow_out}, {30'b0, model(a, b, borrow_in)});
`ifdef FULL_SUBTRACTOR_S_STATS_EN
         check1("cyc_op_count", 32'(op_count), m_op);
         check1("cyc_borrow_count", 32'(borrow_count), m_bc);
`endif
      end
   end

   task automatic drive(input logic [2:0] v, input logic vld);
      @(negedge clk);
      {a, b, borrow_in} = v;
      in_valid = vld;
   endtask

   initial begin
      rst_n = 1'b0; a = 1'b0; b = 1'b0; borrow_in = 1'b0; in_valid = 1'b0;
      #20;
      check1("rst_d_q", {31'b0, d_q}, 32'd0);
      check1("rst_borrow_q", {31'b0, borrow_out_q}, 32'd0);
      check1("rst_out_valid", {31'b0, out_valid}, 32'd0);

      // Combinational sweep with the clock stopped.
      for (int i = 0; i < 8; i++) begin
         logic [2:0] v;
         v = 3'(i);
         {a, b, borrow_in} = v;
         #20;
         check1("comb_lit", {30'b0, d, borrow_out}, {30'b0, tt_lit[i]});
         check1("comb_model", {30'b0, d, borrow_out}, {30'b0, model(v[2], v[1], v[0])});
      end
      {a, b, borrow_in} = 3'b011; #20;
      check1("comb_011", {30'b0, d, borrow_out}, 32'b01);
      {a, b, borrow_in} = 3'b100; #20;
      check1("comb_100", {30'b0, d, borrow_out}, 32'b10);

      clk_en = 1'b1;
      cmp_en = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Registered path and hold.
      drive(3'b111, 1'b1);
      @(posedge clk); #1;
      check1("reg_111", {29'b0, out_valid, d_q, borrow_out_q}, 32'b111);
      drive(3'b000, 1'b0);
      @(posedge clk); #1;
      check1("reg_hold", {29'b0, out_valid, d_q, borrow_out_q}, 32'b011);

      // Asynchronous reset between edges.
      drive(3'b001, 1'b1);
      @(posedge clk); #1;
      check1("cap_001", {29'b0, out_valid, d_q, borrow_out_q}, 32'b111);
      #3;
      rst_n = 1'b0;
      #1;
      check1("async_rst_regs", {29'b0, out_valid, d_q, borrow_out_q}, 32'b000);
      check1("async_rst_comb", {30'b0, d, borrow_out}, 32'b11);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Back-to-back sweep.
      for (int i = 0; i < 8; i++) begin
         drive(3'(i), 1'b1);
         @(posedge clk); #1;
         check1("b2b", {29'b0, out_valid, d_q, borrow_out_q}, {29'b0, 1'b1, tt_lit[i]});
      end
      drive(3'b000, 1'b0);
      @(posedge clk); #1;

`ifdef FULL_SUBTRACTOR_S_STATS_EN
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      drive(3'b001, 1'b1);
      drive(3'b010, 1'b1);
      drive(3'b000, 1'b1);
      drive(3'b111, 1'b1);
      drive(3'b100, 1'b1);
      @(posedge clk); #1;
      check1("stats_op_sat", 32'(op_count), 32'd3);
      check1("stats_borrow", 32'(borrow_count), 32'd3);
      drive(3'b000, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check1("stats_rst_op", 32'(op_count), 32'd0);
      check1("stats_rst_borrow", 32'(borrow_count), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
`endif

      repeat (2) @(posedge clk);
      #2;
      cmp_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
